// File: rtl/kn_rd_pkg.sv
// Shared types and defaults for the knight-rider LED scanner.
package kn_rd_pkg;

   localparam int unsigned NUM_LEDS_DEF = 8;
   localparam int unsigned CNT_W_DEF    = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2
   } state_e;

   function automatic int unsigned pos_w(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/kn_rd_scanner_if.sv
// Control/status bundle of the scanner: config inputs from the register block, LED drive out.
interface kn_rd_scanner_if
   import kn_rd_pkg::*;
#(
   parameter int unsigned NUM_LEDS = NUM_LEDS_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
);

   logic                         cfg_en;
   logic [CNT_W-1:0]             cfg_div;
   logic                         cfg_wr;
   logic [NUM_LEDS-1:0]          led;
   logic [pos_w(NUM_LEDS)-1:0]   pos;
   logic                         dir;
   logic                         sweep_done;

   modport master (
      output cfg_en, cfg_div, cfg_wr,
      input  led, pos, dir, sweep_done
   );

   modport slave (
      input  cfg_en, cfg_div, cfg_wr,
      output led, pos, dir, sweep_done
   );

endinterface

// File: rtl/kn_rd_prescaler.sv
// Step-period prescaler: counts 0..div_q and ticks on the wrap; holds the pending divider.
module kn_rd_prescaler
   import kn_rd_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             run,
   input  logic             idle,
   input  logic             cfg_wr,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             tick
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_div_q, pend_div_d;
   logic             pend_flag_q, pend_flag_d;
   logic             apply;

   always_comb begin
      tick        = run && (cnt_q == div_q);
      apply       = tick || idle;
      cnt_d       = '0;
      div_d       = div_q;
      pend_div_d  = pend_div_q;
      pend_flag_d = pend_flag_q;

      if (run && !tick)
         cnt_d = cnt_q + 1'b1;

      // The tick compares against the old div_q, so a divider loaded here only shapes the next period.
      if (cfg_wr) begin
         pend_div_d = cfg_div;
         if (apply) begin
            div_d       = cfg_div;
            pend_flag_d = 1'b0;
         end else begin
            pend_flag_d = 1'b1;
         end
      end else if (pend_flag_q && apply) begin
         div_d       = pend_div_q;
         pend_flag_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         cnt_q       <= '0;
         div_q       <= '0;
         pend_div_q  <= '0;
         pend_flag_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         pend_div_q  <= pend_div_d;
         pend_flag_q <= pend_flag_d;
      end
   end

endmodule

// File: rtl/kn_rd_scanner.sv
// Back-and-forth LED scanner with programmable step period.
// Optional macro KN_RD_TRAIL_EN adds a one-step trailing LED.
module kn_rd_scanner
   import kn_rd_pkg::*;
#(
   parameter int unsigned NUM_LEDS = NUM_LEDS_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic            ACLK,
   input  logic            ARESET,
   kn_rd_scanner_if.slave  bus
);

   localparam int unsigned        POS_W   = pos_w(NUM_LEDS);
   localparam logic [POS_W-1:0]   POS_MAX = POS_W'(NUM_LEDS - 1);

   if (NUM_LEDS < 2 || NUM_LEDS > 32) begin : g_bad_num_leds
      $fatal(1, "kn_rd_scanner: NUM_LEDS must be in 2..32");
   end

   state_e              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic                dir_q, dir_d;
   logic                sweep_done_q, sweep_done_d;
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic                run, idle, tick;
`ifdef KN_RD_TRAIL_EN
   logic [POS_W-1:0]    prev_pos_q, prev_pos_d;
`endif

   function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
      onehot    = '0;
      onehot[p] = 1'b1;
   endfunction

   always_comb begin
      idle = (state_q == IDLE);
      run  = !idle && bus.cfg_en;
   end

   kn_rd_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .run     (run),
      .idle    (idle),
      .cfg_wr  (bus.cfg_wr),
      .cfg_div (bus.cfg_div),
      .tick    (tick)
   );

   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      dir_d        = dir_q;
      sweep_done_d = 1'b0;
`ifdef KN_RD_TRAIL_EN
      prev_pos_d   = prev_pos_q;
`endif
      case (state_q)
         IDLE: begin
            pos_d = '0;
            dir_d = 1'b0;
            if (bus.cfg_en)
               state_d = UP;
         end
         UP, DOWN: begin
            if (!bus.cfg_en) begin
               state_d = IDLE;
               pos_d   = '0;
               dir_d   = 1'b0;
            end else if (tick) begin
`ifdef KN_RD_TRAIL_EN
               prev_pos_d = pos_q;
`endif
               if (state_q == UP) begin
                  pos_d = pos_q + 1'b1;
                  if (pos_d == POS_MAX) begin
                     state_d = DOWN;
                     dir_d   = 1'b1;
                  end
               end else begin
                  pos_d = pos_q - 1'b1;
                  if (pos_d == '0) begin
                     state_d      = UP;
                     dir_d        = 1'b0;
                     sweep_done_d = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            pos_d   = '0;
            dir_d   = 1'b0;
         end
      endcase

`ifdef KN_RD_TRAIL_EN
      if (state_d == IDLE)
         prev_pos_d = '0;
`endif

      // LEDs are decoded from the next position so led and pos change on the same edge.
      if (state_d == IDLE)
         led_d = '0;
      else
`ifdef KN_RD_TRAIL_EN
         led_d = onehot(pos_d) | onehot(prev_pos_d);
`else
         led_d = onehot(pos_d);
`endif
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= IDLE;
         pos_q        <= '0;
         dir_q        <= 1'b0;
         sweep_done_q <= 1'b0;
         led_q        <= '0;
`ifdef KN_RD_TRAIL_EN
         prev_pos_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         pos_q        <= pos_d;
         dir_q        <= dir_d;
         sweep_done_q <= sweep_done_d;
         led_q        <= led_d;
`ifdef KN_RD_TRAIL_EN
         prev_pos_q   <= prev_pos_d;
`endif
      end
   end

   assign bus.led        = led_q;
   assign bus.pos        = pos_q;
   assign bus.dir        = dir_q;
   assign bus.sweep_done = sweep_done_q;

endmodule

// File: tb/tb_kn_rd_scanner.sv
// Self-checking bench for kn_rd_scanner (NUM_LEDS=8, CNT_W=32); honours KN_RD_TRAIL_EN.
module tb_kn_rd_scanner;

   logic ACLK = 1'b0;
   logic ARESET;
   int   n_checks = 0;
   int   n_fail   = 0;

   kn_rd_scanner_if #(.NUM_LEDS(8), .CNT_W(32)) bus ();

   kn_rd_scanner #(
      .NUM_LEDS (8),
      .CNT_W    (32)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [7:0] led;
      int         pos;
      logic       dir;
      logic       done;
   } exp_t;

   typedef struct {
      logic [31:0] div;
      int          t;
      int          pos;
      logic        dir;
      logic        done;
   } vec_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clk1();
      @(posedge ACLK);
      #1;
   endtask

   // Triangle position for step index k on an 8-LED bar (14 steps per full sweep).
   function automatic int tri_pos(input int k);
      int m;
      m = k % 14;
      return (m <= 7) ? m : 14 - m;
   endfunction

   function automatic exp_t model(input logic [31:0] d, input int t);
      exp_t            e;
      longint unsigned p, tl;
      int              k;
      p      = 64'(d) + 64'd1;
      tl     = 64'(t);
      k      = int'(tl / p);
      e.pos  = tri_pos(k);
      e.dir  = ((k % 14) >= 7);
      e.done = (tl % p == 0) && (k > 0) && (k % 14 == 0);
      e.led  = 8'd1 << e.pos;
`ifdef KN_RD_TRAIL_EN
      if (k > 0)
         e.led = e.led | (8'd1 << tri_pos(k - 1));
`endif
      return e;
   endfunction

   task automatic sb_check();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("sb_led",  bus.led,        e.led);
         check("sb_pos",  bus.pos,        e.pos);
         check("sb_dir",  bus.dir,        e.dir);
         check("sb_done", bus.sweep_done, e.done);
      end
   endtask

   // Reset, write the divider while idle, enable; returns at the first UP cycle (t=0).
   task automatic start(input logic [31:0] d);
      ARESET = 1'b1; bus.cfg_en = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_div = '0;
      clk1();
      ARESET = 1'b0; bus.cfg_div = d; bus.cfg_wr = 1'b1;
      clk1();
      bus.cfg_wr = 1'b0; bus.cfg_en = 1'b1;
      clk1();
   endtask

   task automatic cycles_to_change(output int n);
      logic [2:0] p0;
      p0 = bus.pos;
      n  = 0;
      while (bus.pos == p0 && n < 200) begin
         clk1();
         n++;
      end
   endtask

   task automatic wait_for(input int p, input logic d, output int n);
      n = 0;
      while (!(bus.pos == p && bus.dir == d) && n < 300) begin
         clk1();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[15];
      int   n;

      vecs[0]  = '{32'd3,  0,   0, 1'b0, 1'b0};
      vecs[1]  = '{32'd3,  3,   0, 1'b0, 1'b0};
      vecs[2]  = '{32'd3,  4,   1, 1'b0, 1'b0};
      vecs[3]  = '{32'd3,  28,  7, 1'b1, 1'b0};
      vecs[4]  = '{32'd3,  31,  7, 1'b1, 1'b0};
      vecs[5]  = '{32'd3,  32,  6, 1'b1, 1'b0};
      vecs[6]  = '{32'd3,  56,  0, 1'b0, 1'b1};
      vecs[7]  = '{32'd3,  57,  0, 1'b0, 1'b0};
      vecs[8]  = '{32'd3,  112, 0, 1'b0, 1'b1};
      vecs[9]  = '{32'd0,  0,   0, 1'b0, 1'b0};
      vecs[10] = '{32'd0,  7,   7, 1'b1, 1'b0};
      vecs[11] = '{32'd0,  8,   6, 1'b1, 1'b0};
      vecs[12] = '{32'd0,  14,  0, 1'b0, 1'b1};
      vecs[13] = '{32'd0,  15,  1, 1'b0, 1'b0};
      vecs[14] = '{32'hFFFF_FFFF, 20, 0, 1'b0, 1'b0};

      // Reset state, with enable high to show reset dominates.
      ARESET = 1'b1; bus.cfg_en = 1'b1; bus.cfg_wr = 1'b0; bus.cfg_div = '0;
      clk1();
      clk1();
      check("rst_led",  bus.led,        8'h00);
      check("rst_pos",  bus.pos,        0);
      check("rst_dir",  bus.dir,        0);
      check("rst_done", bus.sweep_done, 0);
      ARESET = 1'b0; bus.cfg_en = 1'b0;
      repeat (3) clk1();
      check("idle_led", bus.led, 8'h00);
      check("idle_pos", bus.pos, 0);

      for (int i = 0; i < 15; i++) begin
         int t;
         start(vecs[i].div);
         t = 0;
         sb.push_back(model(vecs[i].div, 0));
         sb_check();
         while (t < vecs[i].t) begin
            sb.push_back(model(vecs[i].div, t + 1));
            clk1();
            t++;
            sb_check();
         end
         check($sformatf("row%0d_pos", i),  bus.pos,        vecs[i].pos);
         check($sformatf("row%0d_dir", i),  bus.dir,        vecs[i].dir);
         check($sformatf("row%0d_done", i), bus.sweep_done, vecs[i].done);
      end

      // Divider rewritten mid-period: current step unchanged, next one uses the new value.
      start(32'd3);
      clk1(); clk1();
      bus.cfg_div = 32'd9; bus.cfg_wr = 1'b1;
      clk1();
      bus.cfg_wr = 1'b0;
      check("a_pos_t3", bus.pos, 0);
      clk1();
      check("a_pos_t4", bus.pos, 1);
      cycles_to_change(n);
      check("a_step2_len", n, 10);
      cycles_to_change(n);
      check("a_step3_len", n, 10);

      // Two writes in one period: last one wins.
      start(32'd3);
      clk1();
      bus.cfg_div = 32'd1; bus.cfg_wr = 1'b1;
      clk1();
      bus.cfg_div = 32'd5;
      clk1();
      bus.cfg_wr = 1'b0;
      check("b_pos_t3", bus.pos, 0);
      clk1();
      check("b_pos_t4", bus.pos, 1);
      cycles_to_change(n);
      check("b_step2_len", n, 6);
      cycles_to_change(n);
      check("b_step3_len", n, 6);

      // Enable dropped at pos 5 on the way down, then restart.
      start(32'd3);
      wait_for(5, 1'b1, n);
      check("c_reach_pos5", n < 300, 1);
      bus.cfg_en = 1'b0;
      clk1();
      check("c_off_led", bus.led, 8'h00);
      check("c_off_pos", bus.pos, 0);
      check("c_off_dir", bus.dir, 0);
      bus.cfg_en = 1'b1;
      clk1();
      check("c_on_led", bus.led, 8'h01);
      check("c_on_dir", bus.dir, 0);
      cycles_to_change(n);
      check("c_first_step_len", n, 4);
      check("c_first_step_pos", bus.pos, 1);

      // Reset mid-sweep overrides a coincident cfg_wr; divider returns to 0.
      start(32'd3);
      wait_for(3, 1'b0, n);
      check("d_reach_pos3", n < 300, 1);
      ARESET = 1'b1; bus.cfg_div = 32'd5; bus.cfg_wr = 1'b1;
      clk1();
      check("d_rst_led",  bus.led,        8'h00);
      check("d_rst_pos",  bus.pos,        0);
      check("d_rst_dir",  bus.dir,        0);
      check("d_rst_done", bus.sweep_done, 0);
      ARESET = 1'b0; bus.cfg_wr = 1'b0;
      clk1();
      check("d_restart_led", bus.led, 8'h01);
      check("d_restart_pos", bus.pos, 0);
      clk1();
      check("d_tick1_pos", bus.pos, 1);
`ifdef KN_RD_TRAIL_EN
      check("d_tick1_led", bus.led, 8'h03);
`else
      check("d_tick1_led", bus.led, 8'h02);
`endif
      clk1();
      check("d_tick2_pos", bus.pos, 2);
`ifdef KN_RD_TRAIL_EN
      check("d_tick2_led", bus.led, 8'h06);
`else
      check("d_tick2_led", bus.led, 8'h04);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/kn_rd_scanner.md
KN_RD_SCANNER -- requirements
Module: kn_rd_scanner

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 8: number of LED outputs; legal range 2..32, any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the step-period divider.
REQ-003 Port ACLK, input, 1: the single clock; all logic is on the rising edge.
REQ-004 Port ARESET, input, 1: reset, synchronous and active-high.
REQ-005 Port cfg_en, input, 1: run enable, level, from control register bit 0.
REQ-006 Port cfg_div, input, CNT_W: step period in ACLK cycles minus 1, from the period register.
REQ-007 Port cfg_wr, input, 1: one-cycle strobe meaning cfg_div has just been written.
REQ-008 Port led, output, NUM_LEDS: registered LED drive.
REQ-009 Port pos, output, $clog2(NUM_LEDS): current lit position.
REQ-010 Port dir, output, 1: direction; 0 = toward MSB, 1 = toward LSB.
REQ-011 Port sweep_done, output, 1: one-cycle pulse when the scan returns to position 0.

Function
REQ-012 The FSM SHALL have states IDLE, UP and DOWN.
REQ-013 In IDLE: led=0, pos=0, dir=0, prescale counter=0.
REQ-014 IDLE->UP SHALL occur on the first cycle cfg_en=1; led[0]=1 from the next cycle.
REQ-015 The prescaler SHALL count 0..div_q and then wrap; the wrap cycle SHALL be a step tick, giving a period of div_q+1 cycles; div_q=0 SHALL tick every cycle.
REQ-016 In UP, on a tick: pos++; the tick that makes pos=NUM_LEDS-1 SHALL also transition to DOWN with dir=1.
REQ-017 In DOWN, on a tick: pos--; the tick that makes pos=0 SHALL transition to UP with dir=0 and assert sweep_done for exactly that one cycle.
REQ-018 led SHALL equal onehot(pos), updated in the same cycle as pos (0 cycles latency relative to pos).
REQ-019 cfg_en=0 in UP or DOWN SHALL force IDLE on the next edge, clearing pos and the prescaler regardless of any pending tick.
REQ-020 On cfg_wr, cfg_div SHALL be captured into pend_div and pend_flag set; a later cfg_wr before application SHALL overwrite pend_div (last write wins).
REQ-021 pend_div SHALL be loaded into div_q, and pend_flag cleared, on the next tick or in any IDLE cycle.
REQ-022 cfg_wr coincident with a tick SHALL load the new cfg_div directly into div_q at that tick.
REQ-023 Once loaded, a new div_q SHALL take effect for the following period; the period in progress SHALL never be truncated or extended.
REQ-024 Counter arithmetic SHALL be unsigned CNT_W with no overflow; div_q = 2^CNT_W-1 is legal.

Reset
REQ-025 ARESET=1 at an edge SHALL force IDLE, led=0, pos=0, dir=0, sweep_done=0, div_q=0, pend_div=0, pend_flag=0.
REQ-026 Reset asserted mid-sweep SHALL override every other input in that cycle, including cfg_wr.
REQ-027 After release, if cfg_en=1, the FSM SHALL enter UP on the first non-reset edge.

Configuration
REQ-028 The macro KN_RD_TRAIL_EN SHALL, when defined, make led = onehot(pos) | onehot(prev_pos), where prev_pos is the position before the last step.
REQ-029 prev_pos SHALL equal pos in IDLE and until the first tick after start; at a reversal, the trail SHALL show the position just left.
REQ-030 Without KN_RD_TRAIL_EN, led SHALL be strictly one-hot (zero in IDLE) and no prev_pos register SHALL exist.

Structure
REQ-031 Package kn_rd_pkg SHALL hold the state enum (IDLE/UP/DOWN), the NUM_LEDS and CNT_W defaults, and the position-width function.
REQ-032 Sub-module kn_rd_prescaler SHALL own the counter, div_q, pend_div and pend_flag, and SHALL emit the tick.

Verification
REQ-033 NUM_LEDS=8, cfg_div=3, cfg_en=1 after reset -> pos sequence 0..7..0 with 4 cycles per step; sweep_done pulses once every 56 cycles.
REQ-034 cfg_div=0 -> pos changes every cycle; reversal at pos 7 shows pos 6 next cycle, never 7 twice.
REQ-035 cfg_wr with cfg_div=9 two cycles into a 4-cycle period -> current step still takes 4 cycles; the next step takes 10.
REQ-036 cfg_wr with cfg_div=1 then cfg_div=5 in the same period -> only 5 is applied (6-cycle steps).
REQ-037 cfg_en dropped at pos 5 in DOWN -> next cycle led=0, pos=0; re-enable restarts at pos 0 in UP.
REQ-038 ARESET pulsed at pos 3 with KN_RD_TRAIL_EN defined -> led=0 on the next cycle; after restart, led=8'h01, then 8'h03 after the first tick.
